// File: rtl/twisted_ring_counter.sv
// Shift-register phase/sequence generator. It runs as either a Johnson
// (twisted ring, 2*WIDTH states) or a one-hot ring (WIDTH states) counter.
// Features: bidirectional stepping, enable, checked synchronous load, a binary
// phase index and one-cycle wrap / illegal-load pulses.
// Every output comes straight from a flop.
module twisted_ring_counter #(
  parameter int  WIDTH = 4,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] RING_ZERO    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    LAST_JOHNSON = PW'(2*WIDTH-1);
  localparam logic [PW-1:0]    LAST_RING    = PW'(WIDTH-1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             illegal_q, illegal_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] q_fwd, q_rev;
  logic [PW-1:0]    last_phase;
  logic             jn_legal, rg_legal, ld_legal;
  logic [PW-1:0]    jn_idx, rg_idx, ld_idx;

  // Johnson state for phase k: k ones from the bottom up, then (k-W) zeros
  // creeping in from the bottom once the register is full of ones.
  function automatic logic [WIDTH-1:0] johnson_pattern(input int k);
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) begin
      if (k <= WIDTH) p[i] = (i < k);
      else            p[i] = (i >= (k - WIDTH));
    end
    return p;
  endfunction

  function automatic logic [WIDTH-1:0] state_zero(input logic md);
    return md ? RING_ZERO : '0;
  endfunction

  // Next state one step either way; the Johnson twist inverts the fed-back bit.
  always_comb begin
    if (mode_q) begin
      q_fwd = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      q_rev = {q_q[0], q_q[WIDTH-1:1]};
    end else begin
      q_fwd = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      q_rev = {~q_q[0], q_q[WIDTH-1:1]};
    end
    last_phase = mode_q ? LAST_RING : LAST_JOHNSON;
  end

  // Johnson legality: load_val must match exactly one sequence entry.
  always_comb begin
    jn_legal = 1'b0;
    jn_idx   = '0;
    for (int k = 0; k < 2*WIDTH; k++) begin
      if (load_val == johnson_pattern(k)) begin
        jn_legal = 1'b1;
        jn_idx   = PW'(k);
      end
    end
  end

  // Ring legality: exactly one bit set; its position is the phase.
  always_comb begin
    int ones;
    ones   = 0;
    rg_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (load_val[i]) begin
        ones   = ones + 1;
        rg_idx = PW'(i);
      end
    end
    rg_legal = (ones == 1);
  end

  // Select the legality result for the mode currently in effect.
  always_comb begin
    ld_legal = mode_q ? rg_legal : jn_legal;
    ld_idx   = mode_q ? rg_idx   : jn_idx;
  end

  // Per-edge priority below reset: mode change, then load, then step, then hold.
  // phase advances arithmetically alongside q, so there is never a re-decode of q.
  always_comb begin
    q_d       = q_q;
    phase_d   = phase_q;
    mode_d    = mode_q;
    wrap_d    = 1'b0;
    illegal_d = 1'b0;
    if (mode != mode_q) begin
      mode_d  = mode;
      q_d     = state_zero(mode);
      phase_d = '0;
    end else if (load) begin
      if (ld_legal) begin
        q_d     = load_val;
        phase_d = ld_idx;
      end else begin
        q_d       = state_zero(mode_q);
        phase_d   = '0;
        illegal_d = 1'b1;
      end
    end else if (en) begin
      if (dir) begin
        q_d     = q_rev;
        wrap_d  = (phase_q == '0);
        phase_d = (phase_q == '0) ? last_phase : phase_q - 1'b1;
      end else begin
        q_d     = q_fwd;
        wrap_d  = (phase_q == last_phase);
        phase_d = (phase_q == last_phase) ? '0 : phase_q + 1'b1;
      end
    end
  end

  // State registers; reset samples the mode input directly to pick state 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= state_zero(mode);
      phase_q   <= '0;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
      mode_q    <= mode;
    end else begin
      q_q       <= q_d;
      phase_q   <= phase_d;
      wrap_q    <= wrap_d;
      illegal_q <= illegal_d;
      mode_q    <= mode_d;
    end
  end

  assign q       = q_q;
  assign phase   = phase_q;
  assign wrap    = wrap_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_twisted_ring_counter.sv
// Bench for twisted_ring_counter (WIDTH = 4). The reference model tracks only
// the mode and an integer phase. The expected q is rebuilt from the phase
// using the sequence definitions.
module tb_twisted_ring_counter;
  localparam int W  = 4;
  localparam int PW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          reset, en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [PW-1:0] phase;
  logic          wrap, illegal;

  int total = 0;
  int bad   = 0;

  // model state
  bit m_mode;
  int m_ph;
  bit m_wrap, m_ill;

  twisted_ring_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .q(q), .phase(phase), .wrap(wrap), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic int nstates(input bit md);
    return md ? W : 2*W;
  endfunction

  // Sequence entry k of the given mode, from the written-out definition.
  function automatic logic [W-1:0] pat(input bit md, input int k);
    logic [31:0] v;
    if (md)          v = 32'd1 << k;
    else if (k <= W) v = (32'd1 << k) - 1;
    else             v = ((32'd1 << W) - 1) & ~((32'd1 << (k - W)) - 1);
    return v[W-1:0];
  endfunction

  function automatic logic [W+PW+1:0] expv();
    logic [PW-1:0] p;
    p = m_ph[PW-1:0];
    return {pat(m_mode, m_ph), p, m_wrap, m_ill};
  endfunction

  // Drive one cycle's inputs, clock, advance the model, settle past the edge.
  task automatic cyc(input bit r, input bit e, input bit d, input bit md,
                     input bit l, input logic [W-1:0] lv);
    int n, found;
    reset = r; en = e; dir = d; mode = md; load = l; load_val = lv;
    @(posedge clk);
    if (r || md != m_mode) begin
      m_mode = md; m_ph = 0; m_wrap = 0; m_ill = 0;
    end else if (l) begin
      n = nstates(m_mode); found = -1;
      for (int k = 0; k < n; k++) if (pat(m_mode, k) == lv) found = k;
      m_wrap = 0;
      if (found >= 0) begin m_ph = found; m_ill = 0; end
      else begin m_ph = 0; m_ill = 1; end
    end else if (e) begin
      n = nstates(m_mode);
      m_wrap = d ? (m_ph == 0) : (m_ph == n - 1);
      m_ph = d ? (m_ph + n - 1) % n : (m_ph + 1) % n;
      m_ill = 0;
    end else begin
      m_wrap = 0; m_ill = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, '0);
    total++;
    if ({q, phase, wrap, illegal} !== {4'b0000, 3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_johnson got q=%b ph=%0d w=%b i=%b exp q=0000 ph=0 w=0 i=0", q, phase, wrap, illegal);
    end
    cyc(1, 0, 0, 1, 0, '0);
    total++;
    if ({q, phase, wrap, illegal} !== {4'b0001, 3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_ring got q=%b ph=%0d w=%b i=%b exp q=0001 ph=0 w=0 i=0", q, phase, wrap, illegal);
    end
  endtask

  task automatic test_johnson_fwd();
    logic [W-1:0] seq [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                              4'b1110, 4'b1100, 4'b1000, 4'b0000};
    cyc(1, 0, 0, 0, 0, '0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 0, 0, '0);
      total++;
      if ({q, phase, wrap} !== {seq[i], 3'(i % 8), 1'(i == 8)}) begin
        bad++; $display("FAIL johnson_fwd step=%0d got q=%b ph=%0d w=%b exp q=%b ph=%0d w=%b",
                        i, q, phase, wrap, seq[i], i % 8, i == 8);
      end
    end
  endtask

  task automatic test_johnson_rev();
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 1, 1, 0, 0, '0);
    total++;
    if ({q, phase, wrap} !== {4'b1000, 3'd7, 1'b1}) begin
      bad++; $display("FAIL johnson_rev1 got q=%b ph=%0d w=%b exp q=1000 ph=7 w=1", q, phase, wrap);
    end
    cyc(0, 1, 1, 0, 0, '0);
    total++;
    if ({q, phase, wrap} !== {4'b1100, 3'd6, 1'b0}) begin
      bad++; $display("FAIL johnson_rev2 got q=%b ph=%0d w=%b exp q=1100 ph=6 w=0", q, phase, wrap);
    end
    cyc(0, 1, 0, 0, 0, '0);
    total++;
    if ({q, phase, wrap} !== {4'b1000, 3'd7, 1'b0}) begin
      bad++; $display("FAIL johnson_dirflip got q=%b ph=%0d w=%b exp q=1000 ph=7 w=0", q, phase, wrap);
    end
  endtask

  task automatic test_ring();
    logic [W-1:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cyc(1, 0, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 1, 0, '0);
      total++;
      if ({q, phase, wrap} !== {seq[i], 3'((i + 1) % 4), 1'(i == 3)}) begin
        bad++; $display("FAIL ring_fwd step=%0d got q=%b ph=%0d w=%b exp q=%b ph=%0d w=%b",
                        i, q, phase, wrap, seq[i], (i + 1) % 4, i == 3);
      end
    end
    cyc(0, 1, 1, 1, 0, '0);
    total++;
    if ({q, phase, wrap} !== {4'b1000, 3'd3, 1'b1}) begin
      bad++; $display("FAIL ring_rev got q=%b ph=%0d w=%b exp q=1000 ph=3 w=1", q, phase, wrap);
    end
  endtask

  task automatic test_load();
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, 1, 4'b0111);
    total++;
    if ({q, phase, wrap, illegal} !== {4'b0111, 3'd3, 1'b0, 1'b0}) begin
      bad++; $display("FAIL load_legal got q=%b ph=%0d w=%b i=%b exp q=0111 ph=3 w=0 i=0", q, phase, wrap, illegal);
    end
    cyc(0, 0, 0, 0, 1, 4'b0101);
    total++;
    if ({q, phase, wrap, illegal} !== {4'b0000, 3'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL load_illegal got q=%b ph=%0d w=%b i=%b exp q=0000 ph=0 w=0 i=1", q, phase, wrap, illegal);
    end
    cyc(0, 0, 0, 0, 0, '0);
    total++;
    if (illegal !== 1'b0) begin
      bad++; $display("FAIL illegal_pulse got i=%b exp i=0", illegal);
    end
    cyc(0, 0, 0, 0, 1, 4'b0000);
    total++;
    if ({q, wrap} !== {4'b0000, 1'b0}) begin
      bad++; $display("FAIL load_zero got q=%b w=%b exp q=0000 w=0", q, wrap);
    end
    cyc(1, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 1, 1, 4'b0110);
    total++;
    if ({q, phase, illegal} !== {4'b0001, 3'd0, 1'b1}) begin
      bad++; $display("FAIL ring_load_illegal got q=%b ph=%0d i=%b exp q=0001 ph=0 i=1", q, phase, illegal);
    end
  endtask

  task automatic test_mode_switch();
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, '0);
    total++;
    if (q !== 4'b0011) begin
      bad++; $display("FAIL switch_setup got q=%b exp q=0011", q);
    end
    cyc(0, 1, 0, 1, 1, 4'b0100);
    total++;
    if ({q, phase, wrap, illegal} !== {4'b0001, 3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mode_switch got q=%b ph=%0d w=%b i=%b exp q=0001 ph=0 w=0 i=0", q, phase, wrap, illegal);
    end
    cyc(0, 1, 0, 1, 1, 4'b0100);
    total++;
    if ({q, phase} !== {4'b0100, 3'd2}) begin
      bad++; $display("FAIL switch_then_load got q=%b ph=%0d exp q=0100 ph=2", q, phase);
    end
  endtask

  task automatic test_hold_reset();
    cyc(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, i[0], 0, 0, '0);
      total++;
      if ({q, phase, wrap} !== {4'b1110, 3'd5, 1'b0}) begin
        bad++; $display("FAIL hold cyc=%0d got q=%b ph=%0d w=%b exp q=1110 ph=5 w=0", i, q, phase, wrap);
      end
    end
    cyc(1, 1, 0, 0, 1, 4'b0111);
    total++;
    if ({q, phase, wrap, illegal} !== {4'b0000, 3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_priority got q=%b ph=%0d w=%b i=%b exp q=0000 ph=0 w=0 i=0", q, phase, wrap, illegal);
    end
  endtask

  task automatic test_random();
    bit r, e, d, md, l;
    logic [W-1:0] lv;
    logic [W+PW+1:0] exp_v;
    cyc(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      md = ($urandom_range(0, 29) == 0) ? ~m_mode : m_mode;
      l  = ($urandom_range(0, 5) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) lv = pat(m_mode, $urandom_range(0, nstates(m_mode) - 1));
      else                           lv = W'($urandom);
      cyc(r, e, d, md, l, lv);
      exp_v = expv();
      total++;
      if ({q, phase, wrap, illegal} !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d got q=%b ph=%0d w=%b i=%b exp q=%b ph=%0d w=%b i=%b",
                        i, q, phase, wrap, illegal, exp_v[W+PW+1:PW+2], exp_v[PW+1:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  initial begin
    reset = 1; en = 0; dir = 0; mode = 0; load = 0; load_val = '0;
    m_mode = 0; m_ph = 0; m_wrap = 0; m_ill = 0;
    @(negedge clk);
    test_reset();
    test_johnson_fwd();
    test_johnson_rev();
    test_ring();
    test_load();
    test_mode_switch();
    test_hold_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/twisted_ring_counter.md
# twisted_ring_counter

Parametrised shift-register counter. It runs in one of two runtime-selectable modes: Johnson (twisted ring, 2·WIDTH states) or one-hot ring (WIDTH states). It supports bidirectional stepping, count enable, synchronous load with legality checking, a binary phase index, and a rollover pulse. It is the general-purpose phase/sequence generator for timing and multiplexing logic, and it supersedes the fixed 4-bit Johnson counter.

## Interface
- WIDTH, 4, number of register stages; legal range ≥ 2
- PW, $clog2(2*WIDTH), width of the phase index (derived; not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  reset reset, synchronous, active-high; clock clk
- en  in  1  step enable; one step per edge while high
- dir  in  1  0 = forward, 1 = reverse
- mode  in  1  0 = Johnson, 1 = ring
- load  in  1  synchronous load request
- load_val  in  WIDTH  value to load
- q  out  WIDTH  counter state
- phase  out  PW  index of the current state within the active sequence
- wrap  out  1  one-cycle rollover pulse
- illegal  out  1  one-cycle pulse: rejected load

## Operation
- All outputs are registered and update together on the rising edge of clk.
- Johnson forward: q ← {q[W-2:0], ~q[W-1]}.
- Johnson reverse: q ← {~q[0], q[W-1:1]}.
- Johnson legal states, by phase k:
  - 0 ≤ k ≤ W: the low k bits are 1 and all others 0.
  - W < k < 2W: the low (k−W) bits are 0 and all others 1.
- Ring forward: q ← {q[W-2:0], q[W-1]}.
- Ring reverse: q ← {q[0], q[W-1:1]}.
- Ring legal states are one-hot; phase is the index of the set bit.
- State 0 is q = 0 in Johnson mode and q = 1 (bit 0 set) in ring mode.
- The block holds an internal mode_q register, which tracks the mode currently in effect.
- Priority per edge (highest first):
  1. reset: q ← state 0 of the sampled mode; mode_q ← mode; phase ← 0; wrap ← 0; illegal ← 0.
  2. mode ≠ mode_q: reinitialise to state 0 of the new mode; mode_q ← mode; load and en are ignored; wrap ← 0; illegal ← 0.
  3. load:
     - If load_val is legal for mode_q: q ← load_val and phase ← its index.
     - Otherwise: q ← state 0, phase ← 0, illegal ← 1.
     - wrap ← 0 in both cases. en is ignored.
  4. en: step one state in direction dir and update phase.
     - wrap ← 1 iff the step crossed the sequence boundary: forward from the last phase to 0, or reverse from 0 to the last phase.
  5. Otherwise: hold q and phase; wrap ← 0; illegal ← 0.
- The last phase is 2W−1 in Johnson mode and W−1 in ring mode.
- q therefore never holds an illegal state. phase always equals the decode of q.
- The upper values of phase are unused in ring mode.
- dir may change on any cycle; the next step uses the new direction with no penalty.

## Timing
- Reset values: q = 0 if mode = 0 during reset, else 1; phase = 0; wrap = 0; illegal = 0.
- Step latency is 1 cycle: en sampled high at edge n gives the new q, phase and wrap after edge n.
- wrap and illegal are high for exactly one cycle per event.
  - Continuous forward stepping in Johnson mode produces wrap every 2W cycles.
  - Continuous forward stepping in ring mode produces wrap every W cycles.
- A mode change takes effect at the first edge where mode ≠ mode_q. Nothing else advances on that edge.
- Reset asserted mid-count overrides load, en and a pending mode change on the same edge.
- A legal load of the current value is not a step and raises no wrap.
- A load of state 0 does not raise wrap.

## Test plan
- **Johnson forward sweep.** WIDTH = 4, mode = 0. Reset, then en = 1, dir = 0 for 8 edges.
  - Required q sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - phase runs 0 through 7, then 0.
  - wrap = 1 only in the cycle with the final q = 0000.
- **Johnson reverse.** From reset, en = 1, dir = 1.
  - Required q: 1000 (phase 7, wrap = 1), then 1100 (phase 6, wrap = 0).
  - Toggle dir to 0 after that: q returns to 1000.
- **Ring mode.** Reset with mode = 1 → q = 0001.
  - Forward steps: 0010, 0100, 1000, 0001; wrap = 1 on the 4th step.
  - Reverse from 0001 → 1000, phase 3, wrap = 1.
- **Load legality.** mode = 0.
  - load_val = 0111 → q = 0111, phase = 3, illegal = 0.
  - load_val = 0101 → q = 0000, phase = 0, illegal = 1 for one cycle.
  - In ring mode, load_val = 0110 → q = 0001, illegal = 1.
- **Mode switch mid-count.** Johnson mode at q = 0011. Set mode = 1 with load = 1 (load_val = 0100) and en = 1 on the same edge.
  - Required: q = 0001, phase = 0, wrap = 0, illegal = 0; the load is ignored.
  - Next edge with load held: q = 0100.
- **Hold and reset priority.**
  - en = 0 for 5 cycles: q, phase unchanged; wrap = 0.
  - reset = 1 together with load = 1 and en = 1 while at 1110 → q = 0000, all pulses 0.
